// File: rtl/cr16_cond_unit_pkg.sv
// Shared definitions for the CR16 condition unit.
// - Processor Status Register (PSR) width and status bit positions. The ALU
//   uses the same positions when it produces status.
// - The 16 CR16 condition codes used by Bcond/Jcond/Scond.
// - psr_merge(): masked PSR update, shared by the register path and the
//   forwarding path so that both use one definition of a write.
package cr16_cond_unit_pkg;

  localparam int unsigned PsrWidth  = 5;
  localparam int unsigned CondWidth = 4;

  // Status bit positions inside the PSR / ALU status word
  localparam int unsigned BitCarry    = 0;
  localparam int unsigned BitLow      = 1;
  localparam int unsigned BitFlag     = 2;
  localparam int unsigned BitZero     = 3;
  localparam int unsigned BitNegative = 4;

  typedef logic [PsrWidth-1:0]  psr_t;
  typedef logic [CondWidth-1:0] cond_t;

  typedef enum logic [CondWidth-1:0] {
    CondEq = 4'h0,  // Z
    CondNe = 4'h1,  // ~Z
    CondCs = 4'h2,  // C
    CondCc = 4'h3,  // ~C
    CondHi = 4'h4,  // L
    CondLs = 4'h5,  // ~L
    CondGt = 4'h6,  // N
    CondLe = 4'h7,  // ~N
    CondFs = 4'h8,  // F
    CondFc = 4'h9,  // ~F
    CondLo = 4'hA,  // ~L & ~Z
    CondHs = 4'hB,  // L | Z
    CondLt = 4'hC,  // ~N & ~Z
    CondGe = 4'hD,  // N | Z
    CondUc = 4'hE,  // always
    CondNv = 4'hF   // never
  } cond_e;

  // Bits with mask=1 take the new status, the rest keep the current PSR.
  function automatic psr_t psr_merge(psr_t cur, psr_t wdata, psr_t mask);
    return (cur & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/cr16_cond_unit_if.sv
// Interface between the ALU status / branch control side and the condition
// unit.
// - status_we, status, status_mask : masked PSR write from the ALU
// - req_valid, cond, req_ready     : condition-evaluation request handshake
// - resp_valid, taken, resp_ready  : registered result handshake
// - psr                            : current PSR contents
// master = requester / ALU side, slave = the condition unit.
interface cr16_cond_unit_if;
  import cr16_cond_unit_pkg::*;

  logic  status_we;
  psr_t  status;
  psr_t  status_mask;
  logic  req_valid;
  cond_t cond;
  logic  req_ready;
  logic  resp_valid;
  logic  taken;
  logic  resp_ready;
  psr_t  psr;

  modport master (
    output status_we, status, status_mask, req_valid, cond, resp_ready,
    input  req_ready, resp_valid, taken, psr
  );

  modport slave (
    input  status_we, status, status_mask, req_valid, cond, resp_ready,
    output req_ready, resp_valid, taken, psr
  );

endinterface

// File: rtl/cr16_cond_eval.sv
// Purely combinational CR16 condition evaluator.
// Ports:
// - cond  in  4  condition code
// - flags in  5  PSR-format flags {N,Z,F,L,C}
// - taken out 1  1 when the condition holds
// Every one of the 16 codes is decoded, so no input value leaves taken
// undefined. Also instantiated by the Scond datapath.
module cr16_cond_eval
  import cr16_cond_unit_pkg::*;
(
  input  cond_t cond,
  input  psr_t  flags,
  output logic  taken
);

  logic flag_c;
  logic flag_l;
  logic flag_f;
  logic flag_z;
  logic flag_n;

  assign flag_c = flags[BitCarry];
  assign flag_l = flags[BitLow];
  assign flag_f = flags[BitFlag];
  assign flag_z = flags[BitZero];
  assign flag_n = flags[BitNegative];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      CondEq: taken = flag_z;
      CondNe: taken = ~flag_z;
      CondCs: taken = flag_c;
      CondCc: taken = ~flag_c;
      CondHi: taken = flag_l;
      CondLs: taken = ~flag_l;
      CondGt: taken = flag_n;
      CondLe: taken = ~flag_n;
      CondFs: taken = flag_f;
      CondFc: taken = ~flag_f;
      CondLo: taken = ~flag_l & ~flag_z;
      CondHs: taken = flag_l | flag_z;
      CondLt: taken = ~flag_n & ~flag_z;
      CondGe: taken = flag_n | flag_z;
      CondUc: taken = 1'b1;
      CondNv: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_cond_unit.sv
// CR16 condition unit: owns the PSR and answers condition-evaluation requests.
// Ports:
// - clk   in  clock, all state changes on the rising edge
// - reset in  synchronous active-high reset
// - bus   slave side of cr16_cond_unit_if (PSR write, request and response
//         handshakes, PSR readback)
// Parameters:
// - P_PSR_RESET : PSR value after reset
// - P_FORWARD   : 1 = a request accepted together with a PSR write evaluates
//                 the newly written flags; 0 = it evaluates the old PSR
// One registered result per accepted request, one cycle after acceptance.
// req_ready is combinational from resp_ready (no skid buffer), which keeps
// full throughput when the consumer is always ready.
module cr16_cond_unit
  import cr16_cond_unit_pkg::*;
#(
  parameter psr_t P_PSR_RESET = 5'b00000,
  parameter bit   P_FORWARD   = 1'b1
) (
  input logic             clk,
  input logic             reset,
  cr16_cond_unit_if.slave bus
);

  psr_t psr_q;
  psr_t psr_d;
  psr_t psr_merged;
  psr_t eval_flags;
  logic resp_valid_q;
  logic resp_valid_d;
  logic taken_q;
  logic taken_d;
  logic eval_taken;
  logic req_ready;
  logic accept;

  // PSR write path
  assign psr_merged = psr_merge(psr_q, bus.status, bus.status_mask);

  always_comb begin
    psr_d = psr_q;
    if (bus.status_we) begin
      psr_d = psr_merged;
    end
  end

  // Flag source for the evaluator: forward the write in flight if enabled
  always_comb begin
    eval_flags = psr_q;
    if (P_FORWARD && bus.status_we) begin
      eval_flags = psr_merged;
    end
  end

  cr16_cond_eval u_cond_eval (
    .cond  (bus.cond),
    .flags (eval_flags),
    .taken (eval_taken)
  );

  // Handshake: a slot is free when empty or when the held result leaves now
  assign req_ready = ~resp_valid_q | bus.resp_ready;
  assign accept    = bus.req_valid & req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    taken_d      = taken_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      taken_d      = eval_taken;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psr_q        <= P_PSR_RESET;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      psr_q        <= psr_d;
      resp_valid_q <= resp_valid_d;
      taken_q      <= taken_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.taken      = taken_q;
  assign bus.psr        = psr_q;

endmodule

// File: tb/tb_cr16_cond_unit.sv
// Bench for cr16_cond_unit. Two instances share one stimulus stream: u_dut
// forwards same-cycle PSR writes, u_dut_nf does not. A predictor turns each
// accepted request into an expected result pair; a monitor compares results
// as they are presented.
module tb_cr16_cond_unit;
  import cr16_cond_unit_pkg::*;

  localparam psr_t PsrReset = 5'b00000;

  logic clk;
  logic rst;

  cr16_cond_unit_if bus ();
  cr16_cond_unit_if bus_nf ();

  assign bus_nf.status_we   = bus.status_we;
  assign bus_nf.status      = bus.status;
  assign bus_nf.status_mask = bus.status_mask;
  assign bus_nf.req_valid   = bus.req_valid;
  assign bus_nf.cond        = bus.cond;
  assign bus_nf.resp_ready  = bus.resp_ready;

  cr16_cond_unit #(.P_PSR_RESET(PsrReset), .P_FORWARD(1'b1)) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  cr16_cond_unit #(.P_PSR_RESET(PsrReset), .P_FORWARD(1'b0)) u_dut_nf (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic fwd;
    logic nofwd;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Condition codes come in complementary pairs: odd code = ~(even code).
  function automatic logic ref_eval(input logic [3:0] c, input logic [4:0] f);
    logic [7:0] base;
    // pair index: 0 Z, 1 C, 2 L, 3 N, 4 F, 5 ~L&~Z, 6 ~N&~Z, 7 always
    base = {1'b1, ~f[4] & ~f[3], ~f[1] & ~f[3], f[2], f[4], f[1], f[0], f[3]};
    return base[c[3:1]] ^ c[0];
  endfunction

  // Predictor: abstract state is the PSR value and whether a result is pending
  logic [4:0] m_psr;
  logic       m_pend;
  bit         m_known = 1'b0;

  always @(negedge clk) begin
    logic       exp_ready;
    logic       acc;
    logic [4:0] merged;
    exp_t       e;
    exp_ready = !m_pend || bus.resp_ready;
    if (m_known) begin
      chk("psr_fwd", {27'd0, bus.psr}, {27'd0, m_psr});
      chk("psr_nofwd", {27'd0, bus_nf.psr}, {27'd0, m_psr});
      chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, m_pend});
      chk("resp_valid_nf", {31'd0, bus_nf.resp_valid}, {31'd0, m_pend});
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
    end
    if (rst) begin
      m_psr   = PsrReset;
      m_pend  = 1'b0;
      m_known = 1'b1;
      exp_q.delete();
    end else if (m_known) begin
      acc    = bus.req_valid && exp_ready;
      merged = (m_psr & ~bus.status_mask) | (bus.status & bus.status_mask);
      if (acc) begin
        e.fwd   = ref_eval(bus.cond, bus.status_we ? merged : m_psr);
        e.nofwd = ref_eval(bus.cond, m_psr);
        exp_q.push_back(e);
      end
      if (bus.status_we) m_psr = merged;
      if (acc) m_pend = 1'b1;
      else if (bus.resp_ready) m_pend = 1'b0;
    end
  end

  // Monitor: every presented result (held or leaving) must match the oldest
  // outstanding expectation; it is retired when the consumer takes it.
  always @(negedge clk) begin
    if (!rst && m_known && bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        chk("taken_fwd", {31'd0, bus.taken}, {31'd0, exp_q[0].fwd});
        chk("taken_nofwd", {31'd0, bus_nf.taken}, {31'd0, exp_q[0].nofwd});
        if (bus.resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic we, input logic [4:0] st, input logic [4:0] mk,
                      input logic rv, input logic [3:0] cd, input logic rr);
    bus.status_we   = we;
    bus.status      = st;
    bus.status_mask = mk;
    bus.req_valid   = rv;
    bus.cond        = cd;
    bus.resp_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'h00, 5'h00, 1'b0, 4'h0, 1'b1);
  endtask

  logic [15:0] t2_exp;
  logic [3:0]  rc;

  initial begin
    rst = 1'b1;
    bus.status_we   = 1'b0;
    bus.status      = '0;
    bus.status_mask = '0;
    bus.req_valid   = 1'b0;
    bus.cond        = '0;
    bus.resp_ready  = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // T1: reset during an active request with a pending response
    step(1'b1, 5'h1F, 5'h1F, 1'b1, CondUc, 1'b0);
    step(1'b0, 5'h00, 5'h00, 1'b1, CondEq, 1'b0);
    rst = 1'b1;
    step(1'b0, 5'h00, 5'h00, 1'b1, CondUc, 1'b1);
    step(1'b0, 5'h00, 5'h00, 1'b1, CondUc, 1'b1);
    chk("t1_psr", {27'd0, bus.psr}, 32'd0);
    chk("t1_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("t1_taken", {31'd0, bus.taken}, 32'd0);
    rst = 1'b0;
    idle(1);

    // T2: Z only, sweep every condition code
    t2_exp = 16'h6AA9;
    step(1'b1, 5'b01000, 5'h1F, 1'b0, 4'h0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 5'h00, 5'h00, 1'b1, 4'(c), 1'b1);
      chk($sformatf("t2_cond%0h", c), {31'd0, bus.taken}, {31'd0, t2_exp[c]});
    end
    idle(1);

    // T3: masked write keeps carry, sets zero
    step(1'b1, 5'b00001, 5'h1F, 1'b0, 4'h0, 1'b1);
    step(1'b1, 5'b01000, 5'b01000, 1'b0, 4'h0, 1'b1);
    chk("t3_psr", {27'd0, bus.psr}, 32'h09);
    step(1'b0, 5'h00, 5'h00, 1'b1, CondCs, 1'b1);
    chk("t3_cs", {31'd0, bus.taken}, 32'd1);
    step(1'b0, 5'h00, 5'h00, 1'b1, CondEq, 1'b1);
    chk("t3_eq", {31'd0, bus.taken}, 32'd1);
    idle(1);

    // T4: write and request in the same cycle
    step(1'b1, 5'b00000, 5'h1F, 1'b0, 4'h0, 1'b1);
    step(1'b1, 5'b01000, 5'h1F, 1'b1, CondEq, 1'b1);
    chk("t4_fwd", {31'd0, bus.taken}, 32'd1);
    chk("t4_nofwd", {31'd0, bus_nf.taken}, 32'd0);
    idle(1);

    // T5: backpressure holds the UC result and blocks the NV request
    step(1'b0, 5'h00, 5'h00, 1'b1, CondUc, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'h00, 5'h00, 1'b1, CondNv, 1'b0);
      chk("t5_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("t5_hold", {31'd0, bus.taken}, 32'd1);
    end
    step(1'b0, 5'h00, 5'h00, 1'b1, CondNv, 1'b1);
    chk("t5_release", {31'd0, bus.taken}, 32'd0);
    idle(1);

    // T6: back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      rc = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 1'b1, rc, 1'b1);
      chk("t6_valid", {31'd0, bus.resp_valid}, 32'd1);
    end
    idle(1);

    // Random traffic, with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
           1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    idle(4);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
